// File: rtl/dsw_scan.sv
// DIP-switch reader for a 74HC165-style PISO register: periodic load, serial
// shift-in, multi-scan debounce, plus a config-done qualifier counted in scans.
module dsw_scan #(
    parameter int NBIT         = 8,
    parameter int SCAN_DIV     = 250000,
    parameter int CLK_HALF     = 1,
    parameter int DEB_CNT      = 3,
    parameter int DLY_SCANS    = 16,
    parameter int DLY_NEED_VLD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dsw_dat,
    input  logic            c_done,
    output logic            dsw_sht,
    output logic            dsw_clk,
    output logic [NBIT-1:0] dsw_on,
    output logic            dsw_vld,
    output logic            dsw_chg,
    output logic            dsw_tp,
    output logic            c_done_dly
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam int BW = (NBIT > 1) ? $clog2(NBIT) : 1;
    localparam int MW = $clog2(DEB_CNT + 1);
    localparam int DW = $clog2(DLY_SCANS + 1);

    localparam logic [PW-1:0] PER_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NBIT - 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(DEB_CNT - 1);
    localparam logic [DW-1:0] DLY_MAX   = DW'(DLY_SCANS);
    localparam logic          NEED_VLD  = (DLY_NEED_VLD != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   period_q, period_d;
    logic [HW-1:0]   half_q, half_d;
    logic            phase_q, phase_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            load_q, load_d;
    logic [NBIT-1:0] raw_q, raw_d;
    logic [NBIT-1:0] prev_q, prev_d;
    logic [MW-1:0]   match_q, match_d;
    logic [NBIT-1:0] on_q, on_d;
    logic            vld_q, vld_d;
    logic            chg_q, chg_d;
    logic            sht_q, sht_d;
    logic            sclk_q, sclk_d;
    logic            tp_q, tp_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic            accept;

    // Free-running scan period counter, independent of the FSM.
    always_comb begin
        period_d = (period_q == PER_LAST) ? '0 : period_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        load_d  = load_q;
        raw_d   = raw_q;
        case (state_q)
            IDLE: begin
                if (period_q == '0) begin
                    state_d = LOAD;
                    load_d  = 1'b0;
                end
            end
            LOAD: begin
                if (load_q) begin
                    state_d = SHIFT;
                    half_d  = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end else begin
                    load_d = 1'b1;
                end
            end
            SHIFT: begin
                if (half_q == HALF_LAST) begin
                    half_d  = '0;
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        // Last low-phase clock: register output is settled, sample it.
                        raw_d    = raw_q << 1;
                        raw_d[0] = ~dsw_dat;
                    end else if (bit_q == BIT_LAST) begin
                        state_d = DONE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin outputs are registered from the next state so dsw_clk is glitch-free.
    always_comb begin
        sht_d  = (state_d != LOAD);
        sclk_d = (state_d == SHIFT) && phase_d;
        tp_d   = (state_d == DONE);
    end

    always_comb begin
        match_d = match_q;
        prev_d  = prev_q;
        on_d    = on_q;
        vld_d   = vld_q;
        chg_d   = 1'b0;
        accept  = 1'b0;
        if (state_q == DONE) begin
            if (raw_q == prev_q) begin
                match_d = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;
            end else begin
                match_d = '0;
            end
            prev_d = raw_q;
            accept = (match_d == MATCH_MAX);
            if (accept) begin
                on_d  = raw_q;
                vld_d = 1'b1;
                chg_d = vld_q && (raw_q != on_q);
            end
        end
    end

    // Counts completed scans while c_done holds; any low level restarts it.
    always_comb begin
        dly_d = dly_q;
        if (!c_done) begin
            dly_d = '0;
        end else if (tp_q && (dly_q != DLY_MAX)) begin
            dly_d = dly_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            period_q <= '0;
            half_q   <= '0;
            phase_q  <= 1'b0;
            bit_q    <= '0;
            load_q   <= 1'b0;
            raw_q    <= '0;
            prev_q   <= '0;
            match_q  <= '0;
            on_q     <= '0;
            vld_q    <= 1'b0;
            chg_q    <= 1'b0;
            sht_q    <= 1'b1;
            sclk_q   <= 1'b0;
            tp_q     <= 1'b0;
            dly_q    <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            half_q   <= half_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            load_q   <= load_d;
            raw_q    <= raw_d;
            prev_q   <= prev_d;
            match_q  <= match_d;
            on_q     <= on_d;
            vld_q    <= vld_d;
            chg_q    <= chg_d;
            sht_q    <= sht_d;
            sclk_q   <= sclk_d;
            tp_q     <= tp_d;
            dly_q    <= dly_d;
        end
    end

    assign dsw_sht    = sht_q;
    assign dsw_clk    = sclk_q;
    assign dsw_on     = on_q;
    assign dsw_vld    = vld_q;
    assign dsw_chg    = chg_q;
    assign dsw_tp     = tp_q;
    // Combinational on c_done so the qualifier drops in the same cycle.
    assign c_done_dly = c_done && (dly_q == DLY_MAX) && (vld_q || !NEED_VLD);

endmodule

// File: tb/tb_dsw_scan.sv
// Bench for dsw_scan: behavioural 74HC165 model, scan-timing sequences,
// a per-scan debounce vector table and c_done delay / reset corner cases.
module tb_dsw_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       c_done;
    logic [7:0] sw;
    logic [7:0] sr = 8'hFF;
    logic       dsw_dat;

    logic       dsw_sht, dsw_clk, dsw_vld, dsw_chg, dsw_tp, c_done_dly;
    logic [7:0] dsw_on;
    logic       sht2, clk2, vld2, chg2, tp2, dly2;
    logic [7:0] on2;

    int n_vec = 0;
    int n_err = 0;

    dsw_scan #(.NBIT(8), .SCAN_DIV(64), .CLK_HALF(1), .DEB_CNT(3),
               .DLY_SCANS(4), .DLY_NEED_VLD(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .dsw_dat(dsw_dat), .c_done(c_done),
        .dsw_sht(dsw_sht), .dsw_clk(dsw_clk), .dsw_on(dsw_on),
        .dsw_vld(dsw_vld), .dsw_chg(dsw_chg), .dsw_tp(dsw_tp),
        .c_done_dly(c_done_dly)
    );

    dsw_scan #(.NBIT(8), .SCAN_DIV(64), .CLK_HALF(1), .DEB_CNT(3),
               .DLY_SCANS(4), .DLY_NEED_VLD(0)) u_dut_nv (
        .clk(clk), .rst_n(rst_n), .dsw_dat(dsw_dat), .c_done(c_done),
        .dsw_sht(sht2), .dsw_clk(clk2), .dsw_on(on2),
        .dsw_vld(vld2), .dsw_chg(chg2), .dsw_tp(tp2),
        .c_done_dly(dly2)
    );

    // Shift register: closed (ON) switch drives low; Q7 is shifted out first.
    always @(negedge dsw_sht or posedge dsw_clk) begin
        if (!dsw_sht) sr <= ~sw;
        else          sr <= {sr[6:0], 1'b1};
    end
    assign dsw_dat = sr[7];

    typedef struct {
        logic [7:0] sw;
        logic [7:0] on;
        logic       vld;
        int         chg;
    } vec_t;
    vec_t vt [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tp(output int chg_cnt);
        logic seen;
        seen    = 1'b0;
        chg_cnt = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (dsw_chg) chg_cnt++;
            if (dsw_tp) begin
                seen = 1'b1;
                break;
            end
        end
        check("tp_seen", 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_first_scan();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("sht@%0d", c), 32'(dsw_sht), 32'(c >= 2));
            check($sformatf("sclk@%0d", c), 32'(dsw_clk), 32'(c >= 3 && c <= 17 && (c % 2) == 1));
            check($sformatf("tp@%0d", c), 32'(dsw_tp), 32'(c == 18));
        end
        check("first_on", 32'(dsw_on), 32'h00);
        check("first_vld", 32'(dsw_vld), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int chg_n;
        vt[0]  = '{8'hA3, 8'h00, 1'b0, 0};
        vt[1]  = '{8'hA3, 8'hA3, 1'b1, 0};
        vt[2]  = '{8'h5C, 8'hA3, 1'b1, 0};
        vt[3]  = '{8'h5C, 8'hA3, 1'b1, 0};
        vt[4]  = '{8'h5C, 8'h5C, 1'b1, 1};
        vt[5]  = '{8'hA3, 8'h5C, 1'b1, 0};
        vt[6]  = '{8'hA3, 8'h5C, 1'b1, 0};
        vt[7]  = '{8'hA3, 8'hA3, 1'b1, 1};
        vt[8]  = '{8'hFF, 8'hA3, 1'b1, 0};
        vt[9]  = '{8'hA3, 8'hA3, 1'b1, 0};
        vt[10] = '{8'hA3, 8'hA3, 1'b1, 0};
        vt[11] = '{8'hA3, 8'hA3, 1'b1, 0};
        vt[12] = '{8'h00, 8'hA3, 1'b1, 0};
        vt[13] = '{8'h00, 8'hA3, 1'b1, 0};
        vt[14] = '{8'h00, 8'h00, 1'b1, 1};
        vt[15] = '{8'h01, 8'h00, 1'b1, 0};
        vt[16] = '{8'h01, 8'h00, 1'b1, 0};
        vt[17] = '{8'h01, 8'h01, 1'b1, 1};
        vt[18] = '{8'h80, 8'h01, 1'b1, 0};
        vt[19] = '{8'h80, 8'h01, 1'b1, 0};
        vt[20] = '{8'h80, 8'h80, 1'b1, 1};

        // Reset values.
        rst_n  = 1'b0;
        c_done = 1'b0;
        sw     = 8'hA3;
        repeat (3) @(negedge clk);
        check("rst_sht", 32'(dsw_sht), 32'd1);
        check("rst_sclk", 32'(dsw_clk), 32'd0);
        check("rst_on", 32'(dsw_on), 32'h00);
        check("rst_vld", 32'(dsw_vld), 32'd0);
        check("rst_chg", 32'(dsw_chg), 32'd0);
        check("rst_tp", 32'(dsw_tp), 32'd0);
        check("rst_dly", 32'(c_done_dly), 32'd0);
        rst_n = 1'b1;
        check_first_scan();

        // One table row per scan; sampled the cycle after dsw_tp.
        for (int i = 0; i < 21; i++) begin
            sw = vt[i].sw;
            wait_tp(chg_n);
            @(negedge clk);
            if (dsw_chg) chg_n++;
            check($sformatf("vec%0d_on", i), 32'(dsw_on), 32'(vt[i].on));
            check($sformatf("vec%0d_vld", i), 32'(dsw_vld), 32'(vt[i].vld));
            check($sformatf("vec%0d_chg", i), 32'(chg_n), 32'(vt[i].chg));
        end

        // c_done rising at cycle 200 with stable switches.
        sw     = 8'hA3;
        c_done = 1'b0;
        do_reset();
        repeat (200) @(negedge clk);
        c_done = 1'b1;
        repeat (3) wait_tp(chg_n);
        @(negedge clk);
        check("dly_after3", 32'(c_done_dly), 32'd0);
        wait_tp(chg_n);
        check("dly_at4th_tp", 32'(c_done_dly), 32'd0);
        check("vld_at4th_tp", 32'(dsw_vld), 32'd1);
        @(negedge clk);
        check("dly_rise", 32'(c_done_dly), 32'd1);
        c_done = 1'b0;
        #1;
        check("dly_drop", 32'(c_done_dly), 32'd0);
        @(negedge clk);
        c_done = 1'b1;
        #1;
        check("dly_restart0", 32'(c_done_dly), 32'd0);
        repeat (3) wait_tp(chg_n);
        @(negedge clk);
        check("dly_restart3", 32'(c_done_dly), 32'd0);
        wait_tp(chg_n);
        check("dly_restart4_tp", 32'(c_done_dly), 32'd0);
        @(negedge clk);
        check("dly_restart_rise", 32'(c_done_dly), 32'd1);

        // Reset pulled during SHIFT (cycle 9 of the next scan, dsw_clk high).
        repeat (54) @(negedge clk);
        check("mid_sclk", 32'(dsw_clk), 32'd1);
        check("mid_sht", 32'(dsw_sht), 32'd1);
        check("mid_on", 32'(dsw_on), 32'hA3);
        rst_n = 1'b0;
        #1;
        check("midrst_sht", 32'(dsw_sht), 32'd1);
        check("midrst_sclk", 32'(dsw_clk), 32'd0);
        check("midrst_on", 32'(dsw_on), 32'h00);
        check("midrst_vld", 32'(dsw_vld), 32'd0);
        check("midrst_dly", 32'(c_done_dly), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_first_scan();

        // Never-stable switches with c_done held: only the no-vld variant qualifies.
        sw     = 8'hFF;
        c_done = 1'b1;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            wait_tp(chg_n);
            if (k == 4) check("nv_dly_at4th_tp", 32'(dly2), 32'd0);
            @(negedge clk);
            check($sformatf("need_dly_scan%0d", k), 32'(c_done_dly), 32'd0);
            check($sformatf("need_vld_scan%0d", k), 32'(dsw_vld), 32'd0);
            check($sformatf("nv_dly_scan%0d", k), 32'(dly2), 32'(k >= 4));
            sw = ~sw;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
